// File: rtl/output_port_pkg.sv
// rtl/output_port_pkg.sv - shared link geometry, flit encodings and FSM states for output_port
package output_port_pkg;

   localparam int FLIT_WIDTH                  = 16;
   localparam int N_OF_VC                     = 2;
   localparam int N_OF_VN                     = 2;
   localparam int MAX_PACKET_LENGHT           = 5;
   localparam int N_TOT_OF_VC                 = N_OF_VC * N_OF_VN;
   localparam int N_BITS_POINTER              = $clog2(N_TOT_OF_VC);
   localparam int N_BITS_POINTER_FLITS_BUFFER = $clog2(MAX_PACKET_LENGHT);
   localparam int VC_LSB                      = 2;

   typedef enum logic [1:0] {
      FLIT_HEAD      = 2'b00,
      FLIT_BODY      = 2'b01,
      FLIT_TAIL      = 2'b10,
      FLIT_HEAD_TAIL = 2'b11
   } flit_type_t;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ALLOC = 2'b01,
      SEND  = 2'b10
   } state_t;

   // A flit closes its packet when it carries a tail marker of either kind.
   function automatic logic is_last_type(input logic [1:0] t);
      return (flit_type_t'(t) == FLIT_TAIL) || (flit_type_t'(t) == FLIT_HEAD_TAIL);
   endfunction

endpackage

// File: rtl/output_port_vc_credit_tracker.sv
// rtl/output_port_vc_credit_tracker.sv - per-VC downstream credit counters and busy bits
module output_port_vc_credit_tracker
   import output_port_pkg::*;
#(
   parameter int N_CREDITS = MAX_PACKET_LENGHT
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_TOT_OF_VC-1:0]    i_credit,
   input  logic [N_TOT_OF_VC-1:0]    i_free,
   input  logic                      i_consume,
   input  logic [N_BITS_POINTER-1:0] i_consume_vc,
   input  logic                      i_alloc,
   input  logic [N_BITS_POINTER-1:0] i_alloc_vc,
   output logic [N_TOT_OF_VC-1:0]    o_credit_nonzero,
   output logic [N_TOT_OF_VC-1:0]    o_busy
);

   localparam int CW = $clog2(N_CREDITS + 1);

   logic [CW-1:0]          r_credit [N_TOT_OF_VC];
   logic [N_TOT_OF_VC-1:0] r_busy;

   // Credits: a returned slot and a consumed slot on the same VC cancel; returns saturate at full depth.
   // Busy: allocation of a VC overrides a simultaneous release of that same VC.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int v = 0; v < N_TOT_OF_VC; v++) begin
            r_credit[v] <= CW'(N_CREDITS);
         end
         r_busy <= '0;
      end else begin
         for (int v = 0; v < N_TOT_OF_VC; v++) begin
            if (i_credit[v] && !(i_consume && (i_consume_vc == N_BITS_POINTER'(v)))) begin
               if (r_credit[v] != CW'(N_CREDITS)) begin
                  r_credit[v] <= r_credit[v] + 1'b1;
               end
            end else if (!i_credit[v] && i_consume && (i_consume_vc == N_BITS_POINTER'(v))) begin
               r_credit[v] <= r_credit[v] - 1'b1;
            end
            if (i_alloc && (i_alloc_vc == N_BITS_POINTER'(v))) begin
               r_busy[v] <= 1'b1;
            end else if (i_free[v]) begin
               r_busy[v] <= 1'b0;
            end
         end
      end
   end

   // Status flags seen by the allocator and the sender.
   always_comb begin
      for (int v = 0; v < N_TOT_OF_VC; v++) begin
         o_credit_nonzero[v] = (r_credit[v] != '0);
      end
      o_busy = r_busy;
   end

endmodule

// File: rtl/output_port.sv
// rtl/output_port.sv - NIC transmit port: VC allocation and credit-gated flit serialisation
module output_port
   import output_port_pkg::*;
#(
   parameter int N_CREDITS = MAX_PACKET_LENGHT
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  r_msg_to_pkt_i,
   input  logic [MAX_PACKET_LENGHT*FLIT_WIDTH-1:0] packet_i,
   output logic                                  stall_msg_to_pkt_o,
   output logic [FLIT_WIDTH-1:0]                 out_link_o,
   output logic                                  is_valid_o,
   input  logic [N_TOT_OF_VC-1:0]                credit_signal_i,
   input  logic [N_TOT_OF_VC-1:0]                free_signal_i
);

   state_t                                 r_state;
   state_t                                 w_next_state;
   logic [FLIT_WIDTH-1:0]                  r_pkt [MAX_PACKET_LENGHT];
   logic [N_BITS_POINTER-1:0]              r_vn;
   logic [N_BITS_POINTER_FLITS_BUFFER-1:0] r_idx;
   logic [N_BITS_POINTER-1:0]              r_vc_sel;
   logic [FLIT_WIDTH-1:0]                  r_out_link;
   logic                                   r_valid;

   logic [N_BITS_POINTER-1:0] w_head_id;
   logic                      w_found;
   logic [N_BITS_POINTER-1:0] w_cand_vc;
   logic [FLIT_WIDTH-1:0]     w_cur_flit;
   logic [FLIT_WIDTH-1:0]     w_out_flit;
   logic                      w_send;
   logic                      w_last;
   logic                      w_alloc;
   logic [N_TOT_OF_VC-1:0]    w_credit_nonzero;
   logic [N_TOT_OF_VC-1:0]    w_busy;

   output_port_vc_credit_tracker #(.N_CREDITS(N_CREDITS)) u_tracker (
      .clk              (clk),
      .rst              (rst),
      .i_credit         (credit_signal_i),
      .i_free           (free_signal_i),
      .i_consume        (w_send),
      .i_consume_vc     (r_vc_sel),
      .i_alloc          (w_alloc),
      .i_alloc_vc       (w_cand_vc),
      .o_credit_nonzero (w_credit_nonzero),
      .o_busy           (w_busy)
   );

   assign w_head_id = packet_i[VC_LSB +: N_BITS_POINTER];

   // Lowest free VC inside the packet's VN; descending scan so the smallest index is written last.
   always_comb begin
      w_found   = 1'b0;
      w_cand_vc = '0;
      for (int c = N_OF_VC - 1; c >= 0; c--) begin
         if (!w_busy[c * N_OF_VN + int'(r_vn)]) begin
            w_found   = 1'b1;
            w_cand_vc = N_BITS_POINTER'(c * N_OF_VN + int'(r_vn));
         end
      end
   end

   // Current flit with its VC field rewritten to the allocated VC.
   always_comb begin
      w_cur_flit = r_pkt[r_idx];
      w_out_flit = w_cur_flit;
      w_out_flit[VC_LSB +: N_BITS_POINTER] = r_vc_sel;
      w_send  = (r_state == SEND) && w_credit_nonzero[r_vc_sel];
      w_last  = is_last_type(w_cur_flit[1:0]) ||
                (r_idx == N_BITS_POINTER_FLITS_BUFFER'(MAX_PACKET_LENGHT - 1));
      w_alloc = (r_state == ALLOC) && w_found;
   end

   // Next-state logic; the packet ends on the edge its last flit is actually sent.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (r_msg_to_pkt_i)    w_next_state = ALLOC;
         ALLOC:   if (w_found)           w_next_state = SEND;
         SEND:    if (w_send && w_last)  w_next_state = IDLE;
         default:                        w_next_state = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Packet capture, VC latch and registered link output.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < MAX_PACKET_LENGHT; k++) begin
            r_pkt[k] <= '0;
         end
         r_vn       <= '0;
         r_idx      <= '0;
         r_vc_sel   <= '0;
         r_out_link <= '0;
         r_valid    <= 1'b0;
      end else begin
         r_valid <= w_send;
         if ((r_state == IDLE) && r_msg_to_pkt_i) begin
            for (int k = 0; k < MAX_PACKET_LENGHT; k++) begin
               r_pkt[k] <= packet_i[k * FLIT_WIDTH +: FLIT_WIDTH];
            end
            r_vn  <= w_head_id % N_BITS_POINTER'(N_OF_VN);
            r_idx <= '0;
         end
         if (w_alloc) begin
            r_vc_sel <= w_cand_vc;
         end
         if (w_send) begin
            r_out_link <= w_out_flit;
            r_idx      <= r_idx + 1'b1;
         end
      end
   end

   assign stall_msg_to_pkt_o = (r_state != IDLE);
   assign out_link_o         = r_out_link;
   assign is_valid_o         = r_valid;

endmodule

// File: tb/tb_output_port.sv
// tb/tb_output_port.sv - directed table and sequence checks for output_port
module tb_output_port;

   logic        clk;
   logic        rst;
   logic        r_msg_to_pkt_i;
   logic [79:0] packet_i;
   logic        stall_msg_to_pkt_o;
   logic [15:0] out_link_o;
   logic        is_valid_o;
   logic [3:0]  credit_signal_i;
   logic [3:0]  free_signal_i;

   int n_cmp = 0;
   int n_bad = 0;

   output_port dut (
      .clk                (clk),
      .rst                (rst),
      .r_msg_to_pkt_i     (r_msg_to_pkt_i),
      .packet_i           (packet_i),
      .stall_msg_to_pkt_o (stall_msg_to_pkt_o),
      .out_link_o         (out_link_o),
      .is_valid_o         (is_valid_o),
      .credit_signal_i    (credit_signal_i),
      .free_signal_i      (free_signal_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [79:0] P1 = {16'hFFF6, 16'hDDD5, 16'hCCC5, 16'hBBB5, 16'h0004};
   localparam logic [79:0] P2 = {16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'h0007};
   localparam logic [79:0] P3 = {16'h0000, 16'h0000, 16'h0306, 16'h0205, 16'h0104};
   localparam logic [79:0] P4 = {16'h5001, 16'h4001, 16'h3001, 16'h2001, 16'h1000};
   localparam logic [79:0] P5 = {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0AB3};
   localparam logic [79:0] P6 = {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0013};

   typedef struct {
      logic        rst;
      logic        rmsg;
      logic [79:0] pkt;
      logic        v;
      logic        s;
      logic [15:0] link;
   } vec_t;

   vec_t tbl [12];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   task automatic chk_out(input string nm, input logic v, input logic s,
                          input logic do_link, input logic [15:0] l);
      chk({nm, " valid"}, 16'(is_valid_o), 16'(v));
      chk({nm, " stall"}, 16'(stall_msg_to_pkt_o), 16'(s));
      if (do_link) chk({nm, " link"}, out_link_o, l);
   endtask

   task automatic accept(input logic [79:0] p);
      r_msg_to_pkt_i = 1'b1;
      packet_i       = p;
      tick();
      r_msg_to_pkt_i = 1'b0;
   endtask

   initial begin
      logic [15:0] p1_exp [5];
      logic [15:0] p4_exp [5];
      p1_exp = '{16'h0004, 16'hBBB5, 16'hCCC5, 16'hDDD5, 16'hFFF6};
      p4_exp = '{16'h1000, 16'h2001, 16'h3001, 16'h4001, 16'h5001};

      //            rst   rmsg  pkt  valid stall link
      tbl[0]  = '{1'b1, 1'b0, P1, 1'b0, 1'b0, 16'h0000};
      tbl[1]  = '{1'b0, 1'b1, P1, 1'b0, 1'b1, 16'h0000};
      tbl[2]  = '{1'b0, 1'b0, P1, 1'b0, 1'b1, 16'h0000};
      tbl[3]  = '{1'b0, 1'b0, P1, 1'b1, 1'b1, 16'h0004};
      tbl[4]  = '{1'b0, 1'b0, P1, 1'b1, 1'b1, 16'hBBB5};
      tbl[5]  = '{1'b0, 1'b0, P1, 1'b1, 1'b1, 16'hCCC5};
      tbl[6]  = '{1'b0, 1'b0, P1, 1'b1, 1'b1, 16'hDDD5};
      tbl[7]  = '{1'b0, 1'b0, P1, 1'b1, 1'b0, 16'hFFF6};
      tbl[8]  = '{1'b0, 1'b1, P2, 1'b0, 1'b1, 16'hFFF6};
      tbl[9]  = '{1'b0, 1'b0, P2, 1'b0, 1'b1, 16'hFFF6};
      tbl[10] = '{1'b0, 1'b0, P2, 1'b1, 1'b0, 16'h000F};
      tbl[11] = '{1'b0, 1'b0, P2, 1'b0, 1'b0, 16'h000F};

      credit_signal_i = '0;
      free_signal_i   = '0;

      // Reset, a 5-flit packet onto VC1, then a head-tail vn1 packet onto VC3.
      for (int i = 0; i < 12; i++) begin
         rst            = tbl[i].rst;
         r_msg_to_pkt_i = tbl[i].rmsg;
         packet_i       = tbl[i].pkt;
         tick();
         chk_out($sformatf("tbl[%0d]", i), tbl[i].v, tbl[i].s, 1'b1, tbl[i].link);
      end
      r_msg_to_pkt_i = 1'b0;

      // VC1 and VC3 busy: vn1 packet waits in ALLOC until VC1 is freed; VC1 has no credits left.
      accept(P3);
      chk_out("blk accept", 1'b0, 1'b1, 1'b1, 16'h000F);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_out("blk alloc wait", 1'b0, 1'b1, 1'b0, 16'h0);
      end
      free_signal_i = 4'b0010;
      tick();
      free_signal_i = '0;
      chk_out("blk free edge", 1'b0, 1'b1, 1'b0, 16'h0);
      tick();
      chk_out("blk alloc vc1", 1'b0, 1'b1, 1'b0, 16'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_out("cred starved", 1'b0, 1'b1, 1'b1, 16'h000F);
      end
      credit_signal_i = 4'b0010;
      tick();
      credit_signal_i = '0;
      chk_out("cred pulse1", 1'b0, 1'b1, 1'b0, 16'h0);
      tick();
      chk_out("cred flit0", 1'b1, 1'b1, 1'b1, 16'h0104);
      tick();
      chk_out("cred gap", 1'b0, 1'b1, 1'b1, 16'h0104);
      credit_signal_i = 4'b0010;
      tick();
      chk_out("cred pulse2", 1'b0, 1'b1, 1'b0, 16'h0);
      tick();
      credit_signal_i = '0;
      chk_out("cred send+pulse", 1'b1, 1'b1, 1'b1, 16'h0205);
      tick();
      chk_out("cred net kept", 1'b1, 1'b0, 1'b1, 16'h0306);
      tick();
      chk_out("cred idle", 1'b0, 1'b0, 1'b1, 16'h0306);

      // Reset in the middle of a vn0 packet on VC0.
      accept(P4);
      tick();
      tick();
      chk_out("rst pre f0", 1'b1, 1'b1, 1'b1, 16'h1000);
      tick();
      chk_out("rst pre f1", 1'b1, 1'b1, 1'b1, 16'h2001);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_out("rst mid", 1'b0, 1'b0, 1'b1, 16'h0000);

      // Fresh P1 after reset: VC1 free again with full credits; VC0 credit pulses must saturate.
      accept(P1);
      chk_out("post rst accept", 1'b0, 1'b1, 1'b0, 16'h0);
      credit_signal_i = 4'b0001;
      tick();
      chk_out("post rst alloc", 1'b0, 1'b1, 1'b0, 16'h0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_out($sformatf("post rst f%0d", i), 1'b1, (i != 4), 1'b1, p1_exp[i]);
      end
      credit_signal_i = '0;

      // VC0: five flits with forced end consume all credits (saturated at 5, not more).
      accept(P4);
      tick();
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_out($sformatf("forced f%0d", i), 1'b1, (i != 4), 1'b1, p4_exp[i]);
      end
      free_signal_i = 4'b0001;
      tick();
      free_signal_i = '0;
      accept(P5);
      free_signal_i = 4'b0001;
      tick();
      free_signal_i = '0;
      chk_out("sat alloc", 1'b0, 1'b1, 1'b0, 16'h0);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk_out("sat no credit", 1'b0, 1'b1, 1'b1, 16'h5001);
      end
      credit_signal_i = 4'b0001;
      tick();
      credit_signal_i = '0;
      chk_out("sat pulse", 1'b0, 1'b1, 1'b0, 16'h0);
      tick();
      chk_out("sat send", 1'b1, 1'b0, 1'b1, 16'h0AB3);

      // VC0 kept busy (alloc beat the same-edge free), so the next vn0 packet goes to VC2.
      accept(P6);
      tick();
      tick();
      chk_out("alloc wins", 1'b1, 1'b0, 1'b1, 16'h001B);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/output_port.md
Name: output_port

Overview:
NIC transmit-side port. It is the counterpart of input_port.
- Accepts one whole packet at a time from the msg_to_pkt queue, as a flat vector of up to MAX_PACKET_LENGHT flits.
- Allocates a downstream VC within the packet's VN and rewrites each flit's VC field to that VC.
- Serialises the flits onto the router link, gated by per-VC credits.
- Tracks VC occupancy through the router's credit and free pulses.

Parameters:
N_TOT_OF_VC, `N_OF_VC*`N_OF_VN, total VCs on the link
N_BITS_POINTER, clog2(N_TOT_OF_VC), width of the VC id field
N_BITS_POINTER_FLITS_BUFFER, clog2(`MAX_PACKET_LENGHT), flit index width
N_CREDITS, `MAX_PACKET_LENGHT, downstream buffer depth per VC (reset credit value)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
r_msg_to_pkt_i  in  1  queue presents a packet
packet_i  in  `MAX_PACKET_LENGHT*`FLIT_WIDTH  packet; flit k at bits [k*FW+FW-1 : k*FW]
stall_msg_to_pkt_o  out  1  1 = packet not accepted this cycle
out_link_o  out  `FLIT_WIDTH  flit to router
is_valid_o  out  1  out_link_o valid
credit_signal_i  in  N_TOT_OF_VC  one-cycle pulse: one flit slot freed on VC v
free_signal_i  in  N_TOT_OF_VC  one-cycle pulse: VC v released (its tail consumed)

Behaviour:
- Flit format (shared defines):
  - type = bits[1:0]: 00 head, 01 body, 10 tail, 11 head-tail.
  - VC id = bits[N_BITS_POINTER+1:2], with id = vc*`N_OF_VN + vn.
- Reset (rst=1 at an edge):
  - state=IDLE; is_valid_o=0; out_link_o=0; stall_msg_to_pkt_o=0.
  - All busy bits cleared; all credits set to N_CREDITS.
  - A packet in flight is discarded.
- FSM IDLE → ALLOC → SEND → IDLE. stall_msg_to_pkt_o = (state != IDLE), combinational.
- IDLE:
  - Edge with r_msg_to_pkt_i=1: capture packet_i into pkt_reg, set vn = (head VC id) mod `N_OF_VN, idx=0, go to ALLOC.
- ALLOC:
  - Candidates are VCs c*`N_OF_VN+vn with busy=0. Pick the lowest c.
  - On that edge: latch vc_sel, set busy[vc_sel], go to SEND.
  - If no candidate, stay in ALLOC and keep stall asserted.
- SEND, per edge:
  - If credit[vc_sel] != 0:
    - out_link_o <= pkt_reg flit idx with its VC field replaced by vc_sel.
    - is_valid_o <= 1; credit decrements; idx++.
  - Otherwise is_valid_o <= 0.
  - The flit just sent is last if its type is tail or head-tail, or if idx = `MAX_PACKET_LENGHT-1 (forced end). On last, go to IDLE.
- Latency: accept at edge E0, allocate at E1, first flit registered at E2. The next packet is accepted no earlier than the edge after the tail is registered.
- is_valid_o is 0 whenever no flit was registered that edge. out_link_o holds its last value.
- Credit arithmetic:
  - Counter width clog2(N_CREDITS+1).
  - Pulse and send on the same VC in the same edge: net unchanged.
  - Pulse at N_CREDITS: saturate.
- Busy bits:
  - free_signal_i[v] clears busy[v].
  - A free pulse on the VC being allocated in the same edge: the set wins.
  - Free pulses on idle VCs are ignored.

Decomposition:
- NIC-defines.v: flit type encodings, VC-field LSB position, N_CREDITS default.
- NIC_utils.vh: clog2.
- Sub-module vc_credit_tracker holds the per-VC credit counters and busy bits.
  - Inputs: credit/free pulses, consume strobe + vc, allocate strobe + vc.
  - Outputs: credit_nonzero[N_TOT_OF_VC], busy[N_TOT_OF_VC].

Test Plan:
(FW=16, N_OF_VC=2, N_OF_VN=2, MAX=5)
1. Packet {0004,BBB5,CCC5,DDD5,FFF6}, all VCs free → VC id 1 chosen. Outputs 0004,BBB5,CCC5,DDD5,FFF6 on 5 consecutive cycles from E2, is_valid_o=1 throughout. credit[1] 5→0. Stall high from E0+ until after the tail.
2. With VC1 still busy, send head-tail 0x0005|3 = 0x0007 (vn1) → allocated VC id 3, out_link_o=0x000F, one valid cycle.
3. With N_CREDITS=2 and a 4-flit packet → 2 valid flits, then is_valid_o=0 until a credit_signal_i pulse on that VC. Each pulse releases exactly one flit.
4. VC1 and VC3 both busy, new vn1 packet → FSM stays in ALLOC with stall=1. free_signal_i[1] pulse → next edge allocates VC1.
5. Credit pulse on vc_sel in the same cycle a flit is sent → counter unchanged. Pulse at full count → stays 5.
6. rst during flit 2 of 5 → next edge is_valid_o=0, stall=0, all credits 5, no busy bits set. A fresh packet is sent normally.
